// File: rtl/phy_rx_lane_pkg.sv
// rtl/phy_rx_lane_pkg.sv - shared word format and FSM encodings for the serial lane receiver
package phy_rx_lane_pkg;

    localparam int          DEF_WIDTH      = 32;
    localparam logic [31:0] DEF_IDLE_WORD  = 32'hBCBCBCBC;
    localparam int          DEF_SYNC_COUNT = 4;

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

endpackage

// File: rtl/phy_rx_shift.sv
// rtl/phy_rx_shift.sv - bit shift register with combinational idle-word comparator
module phy_rx_shift
    import phy_rx_lane_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] IDLE_WORD = DEF_IDLE_WORD[WIDTH-1:0]
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             serial_in,
    output logic [WIDTH-1:0] sr_next,
    output logic             is_idle
);

    logic [WIDTH-1:0] sr;

    // Decisions look at the word including the bit being sampled this edge.
    always_comb begin
        sr_next = {sr[WIDTH-2:0], serial_in};
        is_idle = (sr_next == IDLE_WORD);
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= sr_next;
        end
    end

endmodule

// File: rtl/phy_rx_lane.sv
// rtl/phy_rx_lane.sv - single-lane word aligner and data deliverer for the phy_tx bit stream
module phy_rx_lane
    import phy_rx_lane_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] IDLE_WORD  = DEF_IDLE_WORD[WIDTH-1:0],
    parameter int               SYNC_COUNT = DEF_SYNC_COUNT
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active
);

    localparam int CW  = $clog2(WIDTH);
    localparam int ICW = $clog2(SYNC_COUNT + 1);

    logic [WIDTH-1:0] sr_next;
    logic             is_idle;
    logic [1:0]       state;
    logic [CW-1:0]    bit_cnt;
    logic [ICW-1:0]   idle_cnt;
    logic             word_end;

    phy_rx_shift #(
        .WIDTH     (WIDTH),
        .IDLE_WORD (IDLE_WORD)
    ) u_shift (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .serial_in (serial_in),
        .sr_next   (sr_next),
        .is_idle   (is_idle)
    );

    assign word_end = (bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= HUNT;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                HUNT: begin
                    // The first full idle match fixes the word boundary.
                    if (is_idle) begin
                        state    <= SYNC;
                        idle_cnt <= ICW'(1);
                        bit_cnt  <= '0;
                    end
                end
                SYNC: begin
                    bit_cnt <= word_end ? '0 : bit_cnt + 1'b1;
                    if (word_end) begin
                        if (is_idle) begin
                            idle_cnt <= idle_cnt + 1'b1;
                            if (idle_cnt == ICW'(SYNC_COUNT - 1)) begin
                                state  <= LOCKED;
                                active <= 1'b1;
                            end
                        end else begin
                            state    <= HUNT;
                            idle_cnt <= '0;
                        end
                    end
                end
                LOCKED: begin
                    bit_cnt <= word_end ? '0 : bit_cnt + 1'b1;
                    if (word_end && !is_idle) begin
                        data_out  <= sr_next;
                        valid_out <= 1'b1;
                    end
                end
                default: begin
                    state    <= HUNT;
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                    active   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phy_rx_lane.sv
// tb/tb_phy_rx_lane.sv - directed self-checking bench for phy_rx_lane
module tb_phy_rx_lane;

    localparam logic [31:0] IDLE = 32'hBCBCBCBC;

    logic        clk_32f = 1'b0;
    logic        reset = 1'b1;
    logic        serial_in = 1'b1;
    logic [31:0] data_out;
    logic        valid_out;
    logic        active;

    int tests = 0;
    int fails = 0;

    phy_rx_lane dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .serial_in (serial_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clock_bit(input logic b);
        @(negedge clk_32f);
        reset     = 1'b0;
        serial_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic do_reset(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_32f);
            reset     = 1'b1;
            serial_in = 1'b1;
            @(posedge clk_32f);
            #1;
            check(tag, {data_out[31:2], data_out[1] | valid_out, data_out[0] | active}, 32'h0);
            check({tag, ".data"}, data_out, 32'h0);
        end
    endtask

    // Bits 0..30 must show no pulse and a steady active; the last bit is checked in full.
    task automatic send_word(input string tag, input logic [31:0] w, input logic exp_v,
                             input logic [31:0] exp_d, input logic exp_a_pre, input logic exp_a);
        int stray = 0;
        for (int i = 31; i >= 0; i--) begin
            clock_bit(w[i]);
            if (i > 0 && (valid_out !== 1'b0 || active !== exp_a_pre)) stray++;
        end
        check({tag, ".mid"}, stray, 0);
        check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, exp_v});
        check({tag, ".data"}, data_out, exp_d);
        check({tag, ".active"}, {31'd0, active}, {31'd0, exp_a});
    endtask

    initial begin
        logic [31:0] cc;
        logic [4:0]  junk;
        int          stray;

        do_reset("t1.reset", 3);

        junk = 5'b10110;
        for (int i = 4; i >= 0; i--) clock_bit(junk[i]);
        check("t2.junk.valid", {31'd0, valid_out}, 32'd0);
        send_word("t2.idle1", IDLE, 1'b0, 32'h0, 1'b0, 1'b0);
        send_word("t2.idle2", IDLE, 1'b0, 32'h0, 1'b0, 1'b0);
        send_word("t2.idle3", IDLE, 1'b0, 32'h0, 1'b0, 1'b0);
        send_word("t2.idle4", IDLE, 1'b0, 32'h0, 1'b0, 1'b1);

        send_word("t3.ffff", 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
        send_word("t3.eeee", 32'hEEEEEEEE, 1'b1, 32'hEEEEEEEE, 1'b1, 1'b1);

        send_word("t4.idle1", IDLE, 1'b0, 32'hEEEEEEEE, 1'b1, 1'b1);
        send_word("t4.idle2", IDLE, 1'b0, 32'hEEEEEEEE, 1'b1, 1'b1);
        send_word("t4.dddd", 32'hDDDDDDDD, 1'b1, 32'hDDDDDDDD, 1'b1, 1'b1);

        do_reset("t5.reset", 1);
        send_word("t5.idle1", IDLE, 1'b0, 32'h0, 1'b0, 1'b0);
        send_word("t5.idle2", IDLE, 1'b0, 32'h0, 1'b0, 1'b0);
        send_word("t5.idle3", IDLE, 1'b0, 32'h0, 1'b0, 1'b0);
        send_word("t5.data", 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b0);
        send_word("t5.relock1", IDLE, 1'b0, 32'h0, 1'b0, 1'b0);
        send_word("t5.relock2", IDLE, 1'b0, 32'h0, 1'b0, 1'b0);
        send_word("t5.relock3", IDLE, 1'b0, 32'h0, 1'b0, 1'b0);
        send_word("t5.relock4", IDLE, 1'b0, 32'h0, 1'b0, 1'b1);
        send_word("t5.a5a5", 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b1);

        cc    = 32'hCCCCCCCC;
        stray = 0;
        for (int i = 31; i >= 16; i--) begin
            clock_bit(cc[i]);
            if (valid_out !== 1'b0 || active !== 1'b1) stray++;
        end
        check("t6.pre", stray, 0);
        do_reset("t6.reset", 1);
        stray = 0;
        for (int i = 15; i >= 0; i--) begin
            clock_bit(cc[i]);
            if (valid_out !== 1'b0 || active !== 1'b0 || data_out !== 32'h0) stray++;
        end
        check("t6.post", stray, 0);
        send_word("t6.idle1", IDLE, 1'b0, 32'h0, 1'b0, 1'b0);
        send_word("t6.idle2", IDLE, 1'b0, 32'h0, 1'b0, 1'b0);
        send_word("t6.idle3", IDLE, 1'b0, 32'h0, 1'b0, 1'b0);
        send_word("t6.idle4", IDLE, 1'b0, 32'h0, 1'b0, 1'b1);
        send_word("t6.0f0f", 32'h0F0F0F0F, 1'b1, 32'h0F0F0F0F, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
